// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP writeback controller.
package fp_wb_pkg;

  localparam int unsigned FP_DW    = 32;
  localparam int unsigned FFLAGS_W = 5;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned NREGS    = 32;

  // fflags bit positions, matching the fcsr layout {NV,DZ,OF,UF,NX}
  localparam int unsigned FFLAG_NX = 0;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_NV = 4;

  typedef struct packed {
    logic [RD_W-1:0]     rd;
    logic [FP_DW-1:0]    data;
    logic [FFLAGS_W-1:0] fflags;
  } fp_wb_req_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO buffering FPU results that lost write-port arbitration.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  fp_wb_req_t wdata_i,
  output fp_wb_req_t head_c,
  output logic       full_c,
  output logic       empty_c
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  fp_wb_req_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Extra MSB on each pointer distinguishes full from empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PW'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[IW-1:0]] <= wdata_i;
  end

  always_comb begin
    head_c  = mem[rd_ptr[IW-1:0]];
    empty_c = (wr_ptr == rd_ptr);
    full_c  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  end

endmodule

// File: rtl/fp_writeback_ctrl.sv
// FP register-file write port owner: arbitrates loads vs FPU results, drives the
// bypass source, tracks pending-write scoreboard and sticky fflags.
module fp_writeback_ctrl
  import fp_wb_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic [4:0]          issue_rd_i,
  input  logic                fpu_valid_i,
  output logic                fpu_ready_o,
  input  logic [4:0]          fpu_rd_i,
  input  logic [DW-1:0]       fpu_result_i,
  input  logic [4:0]          fpu_fflags_i,
  input  logic                lsu_we_i,
  input  logic [4:0]          lsu_rd_i,
  input  logic [DW-1:0]       lsu_data_i,
  output logic                rf_we_o,
  output logic [4:0]          rf_waddr_o,
  output logic [DW-1:0]       rf_wdata_o,
  output logic                bypass_valid_o,
  output logic [4:0]          bypass_rd_o,
  output logic [DW-1:0]       bypass_data_o,
  output logic [NREGS-1:0]    busy_o,
  output logic [FFLAGS_W-1:0] fflags_o,
  input  logic                fflags_clr_i
);

  fp_wb_req_t fpu_req;
  fp_wb_req_t lsu_req;
  fp_wb_req_t fifo_head;
  fp_wb_req_t sel_req;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fpu_fire;
  logic       sel_valid;
  logic [NREGS-1:0]    busy_nxt;
  logic [FFLAGS_W-1:0] fflags_new;
  logic [FFLAGS_W-1:0] fflags_nxt;

  // Ready depends only on FIFO state so the FPU never sees a valid->ready loop
  assign fpu_ready_o = !fifo_full;
  assign fpu_fire    = fpu_valid_i && fpu_ready_o;

  always_comb begin
    fpu_req        = '0;
    fpu_req.rd     = fpu_rd_i;
    fpu_req.data   = FP_DW'(fpu_result_i);
    fpu_req.fflags = fpu_fflags_i;
    lsu_req        = '0;
    lsu_req.rd     = lsu_rd_i;
    lsu_req.data   = FP_DW'(lsu_data_i);
  end

  // Write-port arbitration: load > buffered FPU result > FPU pass-through
  always_comb begin
    sel_valid = 1'b0;
    sel_req   = '0;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    if (lsu_we_i) begin
      sel_valid = 1'b1;
      sel_req   = lsu_req;
      fifo_push = fpu_fire;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_req   = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = fpu_fire;
    end else if (fpu_fire) begin
      sel_valid = 1'b1;
      sel_req   = fpu_req;
    end
  end

  fp_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fpu_req),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  // Clear on writeback first so a same-cycle issue to that register wins
  always_comb begin
    busy_nxt = busy_o;
    if (sel_valid)     busy_nxt[sel_req.rd] = 1'b0;
    if (issue_valid_i) busy_nxt[issue_rd_i] = 1'b1;
  end

  always_comb begin
    fflags_new = sel_valid ? sel_req.fflags : '0;
    fflags_nxt = fflags_clr_i ? fflags_new : (fflags_o | fflags_new);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      busy_o     <= '0;
      fflags_o   <= '0;
    end else begin
      rf_we_o  <= sel_valid;
      busy_o   <= busy_nxt;
      fflags_o <= fflags_nxt;
      if (sel_valid) begin
        rf_waddr_o <= sel_req.rd;
        rf_wdata_o <= DW'(sel_req.data);
      end
    end
  end

  assign bypass_valid_o = rf_we_o;
  assign bypass_rd_o    = rf_waddr_o;
  assign bypass_data_o  = rf_wdata_o;

  // Issue must not target a pending register unless that write retires this cycle
  a_issue_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    issue_valid_i |-> (!busy_o[issue_rd_i] || (sel_valid && sel_req.rd == issue_rd_i)))
    else $error("issue to busy register f%0d", issue_rd_i);

  a_write_is_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    sel_valid |-> busy_o[sel_req.rd])
    else $error("writeback to non-busy register f%0d", sel_req.rd);

endmodule

// File: doc/fp_writeback_ctrl.md
Name: fp_writeback_ctrl

Overview:
- Producer side of FP operand forwarding: owns the single write port of the FP register file.
- Merges FPU results (valid/ready handshake) and FP load data (FLW, fire-and-forget) onto one registered write port.
- Presents that registered write as the bypass source (rd + data) to the operand bypass mux.
- Keeps a 32-entry busy scoreboard for issue stalls and accumulates fflags.

Parameters:
- DW, 32, data width of FP registers and results
- FIFO_DEPTH, 2, FPU result buffer entries (power of two, >=2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- issue_valid_i  in  1  FP-destination instruction (FPU op or FLW) issued this cycle
- issue_rd_i  in  5  destination register of issued instruction
- fpu_valid_i  in  1  FPU result valid
- fpu_ready_o  out  1  result accepted when valid&&ready
- fpu_rd_i  in  5  FPU result destination
- fpu_result_i  in  DW  FPU result data
- fpu_fflags_i  in  5  exception flags (NV,DZ,OF,UF,NX) of this result
- lsu_we_i  in  1  FLW data valid; always taken, never stalled
- lsu_rd_i  in  5  FLW destination
- lsu_data_i  in  DW  FLW data
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  5  write address (registered)
- rf_wdata_o  out  DW  write data (registered)
- bypass_valid_o  out  1  equals rf_we_o
- bypass_rd_o  out  5  equals rf_waddr_o
- bypass_data_o  out  DW  equals rf_wdata_o
- busy_o  out  32  scoreboard, bit r = register r has a pending write
- fflags_o  out  5  sticky accumulated flags
- fflags_clr_i  in  1  clear accumulated flags (CSR write)

Behaviour:
- Reset (sync, rst_i high at posedge): FIFO emptied, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, busy_o=0, fflags_o=0. fpu_ready_o=1 from the first cycle after reset. In-flight results are dropped.
- fpu_ready_o = FIFO not full. Combinational from state only, never from fpu_valid_i.
- Write-source select each cycle, strict priority:
  - (1) lsu_we_i;
  - (2) FIFO head if FIFO non-empty;
  - (3) direct FPU pass-through if FIFO empty and fpu_valid_i.
- The selected source loads the wb register at the next posedge, so rf_we_o is high for exactly 1 cycle per write.
- Latency:
  - Load at cycle N -> rf_we_o at N+1.
  - FPU accept at N with FIFO empty and no load -> rf_we_o at N+1 (pass-through, FIFO not written).
  - Otherwise the accepted result is pushed into the FIFO.
- Simultaneous FIFO pop (head written) and push: both occur, occupancy unchanged. Full FIFO with a pop in the same cycle still holds fpu_ready_o=0 (no full-bypass).
- Ordering: FPU results are written in acceptance order. Loads may overtake buffered FPU results; a WAW hazard is impossible because issue stalls on busy.
- No cycle without an rf write while any FPU result is buffered and lsu_we_i=0.
- Scoreboard:
  - issue_valid_i sets busy[issue_rd_i].
  - busy[r] clears on the posedge that loads the wb register with rd=r, so busy falls the same cycle rf_we_o rises.
  - Set and clear of the same r in one cycle: set wins.
  - Issue to a register already busy, or a write to a non-busy register, is a protocol error; flag it with an assertion.
- x0 is a normal FP register (f0); no special casing.
- fflags:
  - fflags_o |= fpu_fflags_i of each result when it is written to the wb register, not at acceptance.
  - Load writes contribute 0.
  - fflags_clr_i clears; same-cycle clear and new flags -> result equals the new flags only.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally. Full = MSBs differ and indices are equal.

Decomposition:
- Package fp_wb_pkg holds:
  - typedef fp_wb_req_t {rd[4:0], data[DW-1:0], fflags[4:0]};
  - constant FFLAGS_W=5;
  - fflag bit-index localparams.
- One sub-module: fp_wb_fifo, a parametrised synchronous FIFO of fp_wb_req_t with push/pop/full/empty.
- Arbitration, scoreboard and fflags stay in the top module.

Test Plan:
- Single FPU op: issue f5 at c0, fpu_valid with 0x3F800000, fflags=0 at c3 -> rf_we_o/bypass at c4 with rd=5 and data=0x3F800000; busy_o[5] high c1..c3, low from c4.
- Collision: load f2=0x40000000 and FPU f7=0x40400000 both at c0 -> c1 writes f2, c2 writes f7; fpu_ready_o stays 1.
- Backpressure: lsu_we_i high c0..c3 with FPU valid every cycle -> FIFO fills after 2 accepts, fpu_ready_o=0 from c2; after load stops, buffered results are written in order on consecutive cycles.
- fflags: result with NX (0x01) written, then result with OF|NX (0x05) -> fflags_o=0x05; fflags_clr_i together with a write carrying DZ (0x08) -> fflags_o=0x08.
- Scoreboard race: wb writes f9 while issue_rd_i=9 in the same cycle -> busy_o[9] remains 1.
- Reset mid-operation: 2 results buffered, busy=0x84, then rst_i for 1 cycle -> next cycle rf_we_o=0, busy_o=0, fpu_ready_o=1, no stale write afterwards.
